// File: rtl/ram_1r1w_arbiter.sv
// ram_1r1w_arbiter
//
// Shares the write port and the read port of one synchronous 1R1W RAM
// between two requesters. Each port has its own round-robin arbiter with a
// one-bit priority pointer. Accepted reads are tagged with the requester
// index, and the RAM's registered read data is steered back to that
// requester one cycle later.
//
// Parameters:
//   width_p  data width in bits
//   depth_p  RAM depth in words; aw = $clog2(depth_p)
//
// Ports:
//   clk_i            clock; all state updates on the rising edge
//   reset_i          asynchronous, active-high reset
//   wr_valid_i[2]    write request per requester
//   wr_addr_i        write addresses, slice r = [r*aw +: aw]
//   wr_data_i        write data,      slice r = [r*width_p +: width_p]
//   wr_ready_o[2]    write grant
//   rd_valid_i[2]    read request per requester
//   rd_addr_i        read addresses, slice r = [r*aw +: aw]
//   rd_ready_o[2]    read grant
//   rd_data_o        shared read-response data
//   rd_data_valid_o  one-hot response strobe, bit r = response for requester r
//   ram_wr_*         RAM write port
//   ram_rd_*         RAM read port
//   ram_rd_data_i    RAM read data, valid one cycle after ram_rd_valid_o
//
// Build option:
//   RAM_ARB_BYPASS_EN  when defined, a read and a write that handshake in the
//                      same cycle to the same address return the new write
//                      data instead of the old RAM contents.
//
// Handshake: a transfer happens on a rising edge where valid & ready is high.
// Ready is combinational from the valid inputs and the priority pointer;
// valid must never depend on ready. There is no backpressure on responses.

module ram_1r1w_arbiter #(
  parameter int width_p = 8,
  parameter int depth_p = 512,
  localparam int aw = $clog2(depth_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic [1:0]           wr_valid_i,
  input  logic [2*aw-1:0]      wr_addr_i,
  input  logic [2*width_p-1:0] wr_data_i,
  output logic [1:0]           wr_ready_o,

  input  logic [1:0]           rd_valid_i,
  input  logic [2*aw-1:0]      rd_addr_i,
  output logic [1:0]           rd_ready_o,
  output logic [width_p-1:0]   rd_data_o,
  output logic [1:0]           rd_data_valid_o,

  output logic                 ram_wr_valid_o,
  output logic [aw-1:0]        ram_wr_addr_o,
  output logic [width_p-1:0]   ram_wr_data_o,

  output logic                 ram_rd_valid_o,
  output logic [aw-1:0]        ram_rd_addr_o,
  input  logic [width_p-1:0]   ram_rd_data_i
);

  // Priority pointers: 0 favours requester 0 on a tie, 1 favours requester 1.
  logic       wr_ptr_q;
  logic       rd_ptr_q;

  // Outstanding read response: pending flag plus the issuing requester.
  logic       rd_pend_q;
  logic       rd_tag_q;

  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;
  logic       wr_sel;
  logic       rd_sel;

  // Write-port arbiter. Grants are held low while in reset so nothing
  // reaches the RAM.
  always_comb begin
    wr_gnt = 2'b00;
    if (!reset_i) begin
      case (wr_valid_i)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = wr_ptr_q ? 2'b10 : 2'b01;
        default: wr_gnt = 2'b00;
      endcase
    end
  end

  // Read-port arbiter, independent of the write port.
  always_comb begin
    rd_gnt = 2'b00;
    if (!reset_i) begin
      case (rd_valid_i)
        2'b01:   rd_gnt = 2'b01;
        2'b10:   rd_gnt = 2'b10;
        2'b11:   rd_gnt = rd_ptr_q ? 2'b10 : 2'b01;
        default: rd_gnt = 2'b00;
      endcase
    end
  end

  assign wr_ready_o = wr_gnt;
  assign rd_ready_o = rd_gnt;

  // Index of the granted requester; only meaningful when a grant exists.
  assign wr_sel = wr_gnt[1];
  assign rd_sel = rd_gnt[1];

  assign ram_wr_valid_o = |(wr_valid_i & wr_gnt);
  assign ram_wr_addr_o  = wr_sel ? wr_addr_i[aw +: aw] : wr_addr_i[0 +: aw];
  assign ram_wr_data_o  = wr_sel ? wr_data_i[width_p +: width_p]
                                 : wr_data_i[0 +: width_p];

  assign ram_rd_valid_o = |(rd_valid_i & rd_gnt);
  assign ram_rd_addr_o  = rd_sel ? rd_addr_i[aw +: aw] : rd_addr_i[0 +: aw];

  // After a transfer by requester r the pointer moves to the other one, so a
  // continuously requesting client waits at most one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (ram_wr_valid_o) wr_ptr_q <= ~wr_sel;
      if (ram_rd_valid_o) rd_ptr_q <= ~rd_sel;
    end
  end

  // Tag register: the RAM returns data exactly one cycle after the read is
  // issued, so a single entry is enough for one read per cycle. Reset drops
  // any outstanding response immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      rd_pend_q <= ram_rd_valid_o;
      rd_tag_q  <= rd_sel;
    end
  end

  // One-hot by construction: never 2'b11.
  assign rd_data_valid_o = {rd_pend_q & rd_tag_q, rd_pend_q & ~rd_tag_q};

`ifdef RAM_ARB_BYPASS_EN
  // Forwarding register: remembers a same-cycle same-address write so the
  // response shows the new value rather than the RAM's pre-write contents.
  logic               fwd_hit_q;
  logic [width_p-1:0] fwd_data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= ram_wr_valid_o && ram_rd_valid_o &&
                    (ram_wr_addr_o == ram_rd_addr_o);
      fwd_data_q <= ram_wr_data_o;
    end
  end

  assign rd_data_o = fwd_hit_q ? fwd_data_q : ram_rd_data_i;
`else
  // Without forwarding a colliding read returns the old RAM contents.
  assign rd_data_o = ram_rd_data_i;
`endif

endmodule

// File: tb/tb_ram_1r1w_arbiter.sv
// Bench for ram_1r1w_arbiter: a behavioural RAM on the DUT's RAM ports, a
// word-level reference model (memory array + two priority bits) driven by the
// stimulus task, and a monitor that pops expected responses from exp_q.

module tb_ram_1r1w_arbiter;

  localparam int W   = 8;
  localparam int D   = 512;
  localparam int AW  = 9;
  localparam int QW  = 32 + 1 + W;   // {due_cycle, requester, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]      wr_valid_i;
  logic [2*AW-1:0] wr_addr_i;
  logic [2*W-1:0]  wr_data_i;
  logic [1:0]      wr_ready_o;
  logic [1:0]      rd_valid_i;
  logic [2*AW-1:0] rd_addr_i;
  logic [1:0]      rd_ready_o;
  logic [W-1:0]    rd_data_o;
  logic [1:0]      rd_data_valid_o;
  logic            ram_wr_valid_o;
  logic [AW-1:0]   ram_wr_addr_o;
  logic [W-1:0]    ram_wr_data_o;
  logic            ram_rd_valid_o;
  logic [AW-1:0]   ram_rd_addr_o;
  logic [W-1:0]    ram_rd_data_i;

  ram_1r1w_arbiter #(.width_p(W), .depth_p(D)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .wr_valid_i      (wr_valid_i),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .wr_ready_o      (wr_ready_o),
    .rd_valid_i      (rd_valid_i),
    .rd_addr_i       (rd_addr_i),
    .rd_ready_o      (rd_ready_o),
    .rd_data_o       (rd_data_o),
    .rd_data_valid_o (rd_data_valid_o),
    .ram_wr_valid_o  (ram_wr_valid_o),
    .ram_wr_addr_o   (ram_wr_addr_o),
    .ram_wr_data_o   (ram_wr_data_o),
    .ram_rd_valid_o  (ram_rd_valid_o),
    .ram_rd_addr_o   (ram_rd_addr_o),
    .ram_rd_data_i   (ram_rd_data_i)
  );

  // ---------------- behavioural RAM (read-before-write) ----------------
  logic [W-1:0] ram_mem [D];
  initial begin
    for (int i = 0; i < D; i++) ram_mem[i] = '0;
    ram_rd_data_i = '0;
  end
  always @(posedge clk) begin
    if (ram_wr_valid_o) ram_mem[ram_wr_addr_o] <= ram_wr_data_o;
    if (ram_rd_valid_o) ram_rd_data_i <= ram_mem[ram_rd_addr_o];
  end

  // ---------------- reference model state ----------------
  logic [W-1:0] m_mem [D];
  logic         m_wr_ptr;
  logic         m_rd_ptr;
  int           cyc;
  int           n_vec;
  int           n_err;
  logic [QW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: a lone requester wins; on a tie the pointer decides.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // ---------------- driver: one cycle of stimulus + model step ----------------
  task automatic drive(input logic [1:0] wv, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [W-1:0] wd0, input logic [W-1:0] wd1,
                       input logic [1:0] rv, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    logic [1:0]    eg_w, eg_r;
    logic [AW-1:0] wa, ra;
    logic [W-1:0]  wd, rdat;
    @(negedge clk);
    wr_valid_i = wv;
    wr_addr_i  = {wa1, wa0};
    wr_data_i  = {wd1, wd0};
    rd_valid_i = rv;
    rd_addr_i  = {ra1, ra0};
    #1;
    eg_w = rr_pick(wv, m_wr_ptr);
    eg_r = rr_pick(rv, m_rd_ptr);
    wa = eg_w[1] ? wa1 : wa0;
    wd = eg_w[1] ? wd1 : wd0;
    ra = eg_r[1] ? ra1 : ra0;
    check("wr_ready", 32'(wr_ready_o), 32'(eg_w));
    check("rd_ready", 32'(rd_ready_o), 32'(eg_r));
    check("ram_wr_valid", 32'(ram_wr_valid_o), 32'(eg_w != 2'b00));
    check("ram_rd_valid", 32'(ram_rd_valid_o), 32'(eg_r != 2'b00));
    if (eg_w != 2'b00) begin
      check("ram_wr_addr", 32'(ram_wr_addr_o), 32'(wa));
      check("ram_wr_data", 32'(ram_wr_data_o), 32'(wd));
    end
    if (eg_r != 2'b00) begin
      check("ram_rd_addr", 32'(ram_rd_addr_o), 32'(ra));
      rdat = m_mem[ra];
`ifdef RAM_ARB_BYPASS_EN
      if (eg_w != 2'b00 && wa == ra) rdat = wd;
`endif
      exp_q.push_back({32'(cyc + 1), eg_r[1], rdat});
      m_rd_ptr = ~eg_r[1];
    end
    if (eg_w != 2'b00) begin
      m_mem[wa] = wd;
      m_wr_ptr = ~eg_w[1];
    end
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [QW-1:0] e;
    #3;
    if (!reset_i) begin
      if (rd_data_valid_o == 2'b11) check("valid_onehot", 32'(rd_data_valid_o), 32'h1);
      if (exp_q.size() > 0 && exp_q[0][QW-1 -: 32] == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("rsp_valid", 32'(rd_data_valid_o), e[W] ? 32'h2 : 32'h1);
        check("rsp_data", 32'(rd_data_o), 32'(e[W-1:0]));
      end else if (rd_data_valid_o != 2'b00) begin
        check("unexpected_rsp", 32'(rd_data_valid_o), 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    m_wr_ptr = 1'b0; m_rd_ptr = 1'b0;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    reset_i = 1'b1;
    wr_valid_i = 2'b11; rd_valid_i = 2'b11;
    wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
    #12;
    // Requests present during reset must not be granted or reach the RAM.
    check("rst_wr_ready", 32'(wr_ready_o), 32'h0);
    check("rst_rd_ready", 32'(rd_ready_o), 32'h0);
    check("rst_ram_wr_valid", 32'(ram_wr_valid_o), 32'h0);
    check("rst_ram_rd_valid", 32'(ram_rd_valid_o), 32'h0);
    check("rst_rsp_valid", 32'(rd_data_valid_o), 32'h0);
    @(negedge clk);
    wr_valid_i = 2'b00; rd_valid_i = 2'b00;
    reset_i = 1'b0;

    // Round-robin on the write port: 01, 10, 01, 10.
    for (int i = 0; i < 4; i++)
      drive(2'b11, AW'(20 + i), AW'(40 + i), W'(8'h10 + i), W'(8'h80 + i), 2'b00, '0, '0);

    // Read routing: requester 1 writes A5 to 7, then reads it back.
    drive(2'b10, '0, 9'd7, '0, 8'hA5, 2'b00, '0, '0);
    drive(2'b00, '0, '0, '0, '0, 2'b10, '0, 9'd7);

    // Back-to-back reads, alternating requesters.
    drive(2'b01, 9'd3, '0, 8'h11, '0, 2'b00, '0, '0);
    drive(2'b10, '0, 9'd4, '0, 8'h22, 2'b00, '0, '0);
    drive(2'b00, '0, '0, '0, '0, 2'b01, 9'd3, '0);
    drive(2'b00, '0, '0, '0, '0, 2'b10, '0, 9'd4);
    drive(2'b00, '0, '0, '0, '0, 2'b01, 9'd4, '0);

    // Same-cycle write and read to address 5 (holding 00).
    drive(2'b01, 9'd5, '0, 8'h00, '0, 2'b00, '0, '0);
    drive(2'b01, 9'd5, '0, 8'h3C, '0, 2'b10, '0, 9'd5);
    drive(2'b00, '0, '0, '0, '0, 2'b01, 9'd5, '0);

    // Single requester: requester 0 alone while the read pointer favours 1,
    // then a tie shows where the pointer ended up.
    for (int i = 0; i < 3; i++) drive(2'b00, '0, '0, '0, '0, 2'b01, AW'(i), '0);
    drive(2'b00, '0, '0, '0, '0, 2'b11, 9'd3, 9'd4);
    idle();

    // Reset with a read outstanding: the response must vanish at once.
    drive(2'b00, '0, '0, '0, '0, 2'b01, 9'd7, '0);
    @(posedge clk);
    #1 reset_i = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rd_data_valid_o), 32'h0);
    check("midrst_rd_ready", 32'(rd_ready_o), 32'h0);
    check("midrst_ram_rd_valid", 32'(ram_rd_valid_o), 32'h0);
    exp_q.delete();
    @(negedge clk);
    wr_valid_i = 2'b00; rd_valid_i = 2'b00;
    reset_i = 1'b0;
    m_wr_ptr = 1'b0; m_rd_ptr = 1'b0;
    @(posedge clk);
    #1 check("post_rst_rsp_valid", 32'(rd_data_valid_o), 32'h0);
    // Both pointers back at 0: both valid grants requester 0.
    drive(2'b11, 9'd9, 9'd10, 8'h5A, 8'h6B, 2'b11, 9'd9, 9'd10);

    // Randomized traffic over a small address window to force collisions.
    for (int i = 0; i < 400; i++)
      drive(2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
            W'($urandom), W'($urandom),
            2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));

    idle();
    idle();
    idle();
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
